// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous RAM.
// Routes each read response back to its issuer one cycle after acceptance.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [CNT_WIDTH-1:0]  gnt_cnt0,
  output logic [CNT_WIDTH-1:0]  gnt_cnt1
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                 last_gnt;
  logic                 gnt0_p0;
  logic                 gnt1_p0;
  logic                 rd_xfer_p0;
  logic                 rsp_pend_p1;
  logic                 rsp_port_p1;
  logic [CNT_WIDTH-1:0] gnt_cnt0_q;
  logic [CNT_WIDTH-1:0] gnt_cnt1_q;

  // Stage p0: combinational grant and RAM drive
  always_comb begin
    gnt0_p0 = !rst && req0_valid && (!req1_valid || last_gnt);
    gnt1_p0 = !rst && req1_valid && (!req0_valid || !last_gnt);
  end

  assign req0_ready = gnt0_p0;
  assign req1_ready = gnt1_p0;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0_p0) begin
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_din  = req0_wdata;
    end else if (gnt1_p0) begin
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
    end
  end

  assign rd_xfer_p0 = (gnt0_p0 && !req0_we) || (gnt1_p0 && !req1_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt    <= 1'b1;
      rsp_pend_p1 <= 1'b0;
      gnt_cnt0_q  <= '0;
      gnt_cnt1_q  <= '0;
    end else begin
      if (gnt0_p0) begin
        last_gnt   <= 1'b0;
        gnt_cnt0_q <= sat_inc(gnt_cnt0_q);
      end
      if (gnt1_p0) begin
        last_gnt   <= 1'b1;
        gnt_cnt1_q <= sat_inc(gnt_cnt1_q);
      end
      rsp_pend_p1 <= rd_xfer_p0;
    end
  end

  // The port tag is only meaningful while rsp_pend_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    rsp_port_p1 <= gnt1_p0;
  end

  // Stage p1: RAM data is back; steer it to the issuing port
  assign rsp0_valid = rsp_pend_p1 && !rsp_port_p1;
  assign rsp1_valid = rsp_pend_p1 &&  rsp_port_p1;
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with a behavioural RAM model.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, we0, v1, we1;
  logic [6:0] a0, a1;
  logic [7:0] d0, d1;
  logic       r0, r1, s0v, s1v, rwe;
  logic [7:0] s0d, s1d, rdin, rdout;
  logic [6:0] raddr;
  logic [15:0] c0, c1;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .rsp0_valid(s0v), .rsp0_rdata(s0d), .rsp1_valid(s1v), .rsp1_rdata(s1d),
    .ram_we(rwe), .ram_addr(raddr), .ram_din(rdin), .ram_dout(rdout),
    .gnt_cnt0(c0), .gnt_cnt1(c1)
  );

  // Registered, read-before-write RAM
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (rwe) mem[raddr] <= rdin;
    rdout <= mem[raddr];
  end

  // Small-counter instance for saturation
  logic       b_rst, b_v0, b_r0, b_r1, b_s0v, b_s1v, b_rwe;
  logic [7:0] b_s0d, b_s1d, b_din, b_dout;
  logic [6:0] b_addr;
  logic [2:0] b_c0, b_c1;
  assign b_dout = 8'h00;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(b_rst),
    .req0_valid(b_v0), .req0_ready(b_r0), .req0_we(1'b1), .req0_addr(7'h03), .req0_wdata(8'h44),
    .req1_valid(1'b0), .req1_ready(b_r1), .req1_we(1'b0), .req1_addr(7'h00), .req1_wdata(8'h00),
    .rsp0_valid(b_s0v), .rsp0_rdata(b_s0d), .rsp1_valid(b_s1v), .rsp1_rdata(b_s1d),
    .ram_we(b_rwe), .ram_addr(b_addr), .ram_din(b_din), .ram_dout(b_dout),
    .gnt_cnt0(b_c0), .gnt_cnt1(b_c1)
  );

  typedef struct {
    logic rst;
    logic v0; logic we0; logic [6:0] a0; logic [7:0] d0;
    logic v1; logic we1; logic [6:0] a1; logic [7:0] d1;
    logic r0; logic r1; logic rwe; logic [6:0] raddr;
    logic s0v; logic [7:0] s0d; logic s1v; logic [7:0] s1d;
    int c0; int c1;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    logic rst_i, logic v0_i, logic we0_i, logic [6:0] a0_i, logic [7:0] d0_i,
    logic v1_i, logic we1_i, logic [6:0] a1_i, logic [7:0] d1_i,
    logic r0_i, logic r1_i, logic rwe_i, logic [6:0] raddr_i,
    logic s0v_i, logic [7:0] s0d_i, logic s1v_i, logic [7:0] s1d_i,
    int c0_i, int c1_i);
    vec_t t;
    t.rst = rst_i; t.v0 = v0_i; t.we0 = we0_i; t.a0 = a0_i; t.d0 = d0_i;
    t.v1 = v1_i; t.we1 = we1_i; t.a1 = a1_i; t.d1 = d1_i;
    t.r0 = r0_i; t.r1 = r1_i; t.rwe = rwe_i; t.raddr = raddr_i;
    t.s0v = s0v_i; t.s0d = s0d_i; t.s1v = s1v_i; t.s1d = s1d_i;
    t.c0 = c0_i; t.c1 = c1_i;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_i, input logic v0_i, input logic we0_i, input logic [6:0] a0_i,
                       input logic [7:0] d0_i, input logic v1_i, input logic we1_i,
                       input logic [6:0] a1_i, input logic [7:0] d1_i);
    rst = rst_i; v0 = v0_i; we0 = we0_i; a0 = a0_i; d0 = d0_i;
    v1 = v1_i; we1 = we1_i; a1 = a1_i; d1 = d1_i;
  endtask

  vec_t vecs [22];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    b_rst = 1'b1; b_v0 = 1'b0;

    //        rst v0 we0 a0    d0     v1 we1 a1    d1     r0 r1 we addr   s0v s0d    s1v s1d    c0 c1
    vecs[0]  = mk(1, 1, 1, 'h10, 'hA5, 1, 1, 'h20, 'h77, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0, 0);
    vecs[1]  = mk(0, 1, 1, 'h10, 'hA5, 0, 0, 'h00, 'h00, 1, 0, 1, 'h10, 0, 'h00, 0, 'h00, 0, 0);
    vecs[2]  = mk(0, 1, 0, 'h10, 'h00, 0, 0, 'h00, 'h00, 1, 0, 0, 'h10, 0, 'h00, 0, 'h00, 1, 0);
    vecs[3]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0, 0, 'h00, 1, 'hA5, 0, 'h00, 2, 0);
    vecs[4]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 2, 0);
    vecs[5]  = mk(0, 1, 1, 'h01, 'h11, 0, 0, 'h00, 'h00, 1, 0, 1, 'h01, 0, 'h00, 0, 'h00, 2, 0);
    vecs[6]  = mk(0, 0, 0, 'h00, 'h00, 1, 1, 'h02, 'h22, 0, 1, 1, 'h02, 0, 'h00, 0, 'h00, 3, 0);
    vecs[7]  = mk(0, 1, 1, 'h05, 'h55, 0, 0, 'h00, 'h00, 1, 0, 1, 'h05, 0, 'h00, 0, 'h00, 3, 1);
    vecs[8]  = mk(1, 0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 4, 1);
    vecs[9]  = mk(0, 1, 0, 'h01, 'h00, 1, 0, 'h02, 'h00, 1, 0, 0, 'h01, 0, 'h00, 0, 'h00, 0, 0);
    vecs[10] = mk(0, 0, 0, 'h00, 'h00, 1, 0, 'h02, 'h00, 0, 1, 0, 'h02, 1, 'h11, 0, 'h00, 1, 0);
    vecs[11] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0, 0, 'h00, 0, 'h00, 1, 'h22, 1, 1);
    vecs[12] = mk(0, 0, 0, 'h00, 'h00, 1, 1, 'h7F, 'h3C, 0, 1, 1, 'h7F, 0, 'h00, 0, 'h00, 1, 1);
    vecs[13] = mk(0, 1, 0, 'h7F, 'h00, 0, 0, 'h00, 'h00, 1, 0, 0, 'h7F, 0, 'h00, 0, 'h00, 1, 2);
    vecs[14] = mk(0, 1, 0, 'h05, 'h00, 0, 0, 'h00, 'h00, 1, 0, 0, 'h05, 1, 'h3C, 0, 'h00, 2, 2);
    vecs[15] = mk(0, 0, 0, 'h00, 'h00, 1, 1, 'h05, 'h99, 0, 1, 1, 'h05, 1, 'h55, 0, 'h00, 3, 2);
    vecs[16] = mk(0, 1, 0, 'h05, 'h00, 0, 0, 'h00, 'h00, 1, 0, 0, 'h05, 0, 'h00, 0, 'h00, 3, 3);
    vecs[17] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0, 0, 'h00, 1, 'h99, 0, 'h00, 4, 3);
    vecs[18] = mk(0, 1, 0, 'h10, 'h00, 0, 0, 'h00, 'h00, 1, 0, 0, 'h10, 0, 'h00, 0, 'h00, 4, 3);
    vecs[19] = mk(1, 0, 0, 'h00, 'h00, 1, 1, 'h20, 'h77, 0, 0, 0, 'h00, 1, 'hA5, 0, 'h00, 5, 3);
    vecs[20] = mk(1, 0, 0, 'h00, 'h00, 1, 1, 'h20, 'h77, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0, 0);
    vecs[21] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0, 0);

    repeat (2) @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #2;
      chk($sformatf("v%0d ready0", i), r0, vecs[i].r0);
      chk($sformatf("v%0d ready1", i), r1, vecs[i].r1);
      chk($sformatf("v%0d ram_we", i), rwe, vecs[i].rwe);
      chk($sformatf("v%0d ram_addr", i), raddr, vecs[i].raddr);
      chk($sformatf("v%0d rsp0_valid", i), s0v, vecs[i].s0v);
      chk($sformatf("v%0d rsp0_rdata", i), s0d, vecs[i].s0d);
      chk($sformatf("v%0d rsp1_valid", i), s1v, vecs[i].s1v);
      chk($sformatf("v%0d rsp1_rdata", i), s1d, vecs[i].s1d);
      chk($sformatf("v%0d gnt_cnt0", i), c0, vecs[i].c0);
      chk($sformatf("v%0d gnt_cnt1", i), c1, vecs[i].c1);
    end

    // Sustained contention: both ports read every cycle for 20 cycles
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0, 1, 0, 'h01, 0, 1, 0, 'h02, 0);
      #2;
      chk($sformatf("rr%0d ready0", k), r0, (k % 2) == 0);
      chk($sformatf("rr%0d ready1", k), r1, (k % 2) == 1);
      if (k > 0) begin
        chk($sformatf("rr%0d rsp0_valid", k), s0v, ((k - 1) % 2) == 0);
        chk($sformatf("rr%0d rsp1_valid", k), s1v, ((k - 1) % 2) == 1);
        chk($sformatf("rr%0d rsp_data", k), ((k - 1) % 2 == 0) ? s0d : s1d,
            ((k - 1) % 2 == 0) ? 8'h11 : 8'h22);
      end else begin
        chk("rr0 no rsp", {s0v, s1v}, 2'b00);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rr tail rsp1_valid", s1v, 1'b1);
    chk("rr tail rsp1_rdata", s1d, 8'h22);
    chk("rr tail rsp0_valid", s0v, 1'b0);
    chk("rr gnt_cnt0", c0, 16'd10);
    chk("rr gnt_cnt1", c1, 16'd10);

    // Saturation on a 3-bit counter
    @(negedge clk);
    b_rst = 1'b0;
    b_v0  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk($sformatf("sat%0d ready0", k), b_r0, 1'b1);
      if (k == 6) chk("sat gnt_cnt0 after 6", b_c0, 3'd6);
      @(negedge clk);
    end
    b_v0 = 1'b0;
    #2;
    chk("sat gnt_cnt0", b_c0, 3'd7);
    chk("sat gnt_cnt1", b_c1, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
